div_iter: RTL
=============

# div_iter

Iterative multi-cycle divider for the five-stage MIPS pipeline, executing DIV/DIVU in the execute stage. It is the source end of the hazard unit's divide stall: it raises `div_stall` to freeze F/D/E while it iterates and returns quotient/remainder for the HI/LO write. It honours the pipeline's execute-stage flush so that an annulled divide never writes HI/LO.

## Interface
- `WIDTH`, 32: operand width; quotient and remainder are also `WIDTH` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  a divide instruction is in E; held high for as long as the instruction stays in E.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `a`  in  WIDTH  dividend, sampled in the start cycle.
- `b`  in  WIDTH  divisor, sampled in the start cycle.
- `flush`  in  1  annul the E-stage instruction; driven from the pipeline's flushE.
- `div_stall`  out  1  drives the hazard unit's `div_stallE` input.
- `result_valid`  out  1  one-cycle pulse; `hi`/`lo` are valid in this cycle.
- `hi`  out  WIDTH  remainder.
- `lo`  out  WIDTH  quotient.

## Operation
- States: IDLE, BUSY, DONE. `resetn` low forces IDLE asynchronously; `hi`, `lo`, `result_valid` and the iteration counter go to 0. `div_stall` is 0 in reset.
- IDLE:
  - With `start & ~flush`: latch |a| and |b|, the quotient sign (sa^sb, signed only) and the remainder sign (sa, signed only), clear the partial remainder, and go to BUSY with counter = 0.
  - With `start & flush`: stay in IDLE; nothing is latched.
- BUSY: one restoring step per cycle.
  - Shift {rem, dividend} left by 1 and trial-subtract the divisor.
  - If the subtraction does not underflow, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - After step WIDTH-1 (counter == WIDTH-1), go to DONE.
- DONE:
  - Register the sign-corrected results: `lo` = quotient, negated if the quotient sign is set; `hi` = remainder, negated if the remainder sign is set.
  - Assert `result_valid` for exactly this cycle, then go to IDLE unconditionally. `start` still being high here belongs to the same instruction and must not restart.
- `div_stall` = `(IDLE & start & ~flush) | (BUSY & ~flush)`. It is combinational so that F/D/E freeze in the same cycle the divide reaches E.
- `flush` in BUSY or DONE: next state is IDLE, `result_valid` is suppressed, and `hi`/`lo` keep their previous values.
- Arithmetic:
  - Magnitudes are computed in WIDTH bits and treated as unsigned, so |0x80000000| = 0x80000000 is exact.
  - The partial remainder is WIDTH+1 bits for the trial subtract.
  - 0x80000000 / -1 (signed) gives `lo` = 0x80000000, `hi` = 0.
- Divide by zero: no trap and normal latency. The restoring algorithm naturally yields `lo` = all ones and `hi` = |a|, with sign correction applied as usual. This value is fixed as the required result, including in signed mode.
- `hi` and `lo` hold their last completed result between divides.

## Timing
- Start cycle t: IDLE with `start`=1, `div_stall`=1.
- Cycles t+1 .. t+WIDTH: BUSY, `div_stall`=1.
- Cycle t+WIDTH+1: DONE, `div_stall`=0, `result_valid`=1, `hi`/`lo` valid. E advances at the end of this cycle.
- Total stall is WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back divides: the following divide reaches E at t+WIDTH+2 and starts from IDLE with no bubble beyond its own stall.
- Reset mid-operation: outputs are 0 immediately (asynchronous), and operation resumes only on a new `start` after `resetn` rises.
- A flush in the start cycle produces no stall at all.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, BUSY, DONE};
  - `DIV_W` = 32;
  - counter width `$clog2(DIV_W)`.
- Single module, no sub-module. The restoring step is a few lines inline; magnitude and negate are local functions.

## Test plan
- DIVU 100/7 with `start` at t: `div_stall` high t..t+32; at t+33 `result_valid`=1, `lo`=14, `hi`=2.
- DIV 0xFFFFFFF9 / 2 (-7/2): `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1) at t+33.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0; DIVU 0xFFFFFFFF / 1: `lo`=0xFFFFFFFF, `hi`=0.
- DIVU 5/0: `lo`=0xFFFFFFFF, `hi`=5 at t+33, with no early completion.
- `flush` pulsed at t+10 during BUSY: `div_stall` low at t+10, no `result_valid`, `hi`/`lo` unchanged. A new DIVU 9/3 started at t+12 completes at t+45 with `lo`=3, `hi`=0.
- `resetn` low at t+5 mid-divide: `div_stall`, `result_valid`, `hi`, `lo` all 0 immediately. After release, a new divide behaves as in the first scenario. Also check that holding `start` high through DONE does not cause a second `result_valid`.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: operand width, counter width and FSM encodings.
package div_pkg;

   localparam int unsigned DIV_W     = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_W);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/div_iter_if.sv
// Execute-stage divide request/response bundle between the pipeline and div_iter.
interface div_iter_if
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W
);

   logic             start;
   logic             signed_div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             div_stall;
   logic             result_valid;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, signed_div, a, b, flush,
      input  div_stall, result_valid, hi, lo
   );

   modport slave (
      input  start, signed_div, a, b, flush,
      output div_stall, result_valid, hi, lo
   );

endinterface

// File: rtl/div_iter.sv
// Restoring multi-cycle DIV/DIVU unit for the E stage; stalls F/D/E while iterating
// and presents the sign-corrected quotient (lo) and remainder (hi) for one cycle.
module div_iter
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W
) (
   input  logic       clk,
   input  logic       resetn,
   div_iter_if.slave  bus
);

   localparam int unsigned CNT_W = (WIDTH == DIV_W) ? DIV_CNT_W : $clog2(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] dvd_q,   dvd_d;
   logic [WIDTH-1:0] dvs_q,   dvs_d;
   logic [WIDTH:0]   rem_q,   rem_d;
   logic             qneg_q,  qneg_d;
   logic             rneg_q,  rneg_d;
   logic [WIDTH-1:0] hi_q,    hi_d;
   logic [WIDTH-1:0] lo_q,    lo_d;

   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;
   logic             done_ok;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? (WIDTH'(0) - x) : x;
   endfunction

   function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? (WIDTH'(0) - x) : x;
   endfunction

   // Remainder never exceeds WIDTH bits, so the top bit of trial is a clean underflow flag.
   assign trial   = {rem_q, dvd_q[WIDTH-1]} - (WIDTH+2)'(dvs_q);
   assign q_res   = negate_if(dvd_q, qneg_q);
   assign r_res   = negate_if(rem_q[WIDTH-1:0], rneg_q);
   assign done_ok = (state_q == DONE) && !bus.flush;

   assign bus.div_stall    = resetn && !bus.flush &&
                             (((state_q == IDLE) && bus.start) || (state_q == BUSY));
   assign bus.result_valid = done_ok;
   assign bus.lo           = done_ok ? q_res : lo_q;
   assign bus.hi           = done_ok ? r_res : hi_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               dvd_d   = magnitude(bus.a, bus.signed_div);
               dvs_d   = magnitude(bus.b, bus.signed_div);
               rem_d   = '0;
               qneg_d  = bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               rneg_d  = bus.signed_div && bus.a[WIDTH-1];
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               if (trial[WIDTH+1]) begin
                  rem_d = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
                  dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
               end else begin
                  rem_d = trial[WIDTH:0];
                  dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // Held start here is still the same instruction, so always return to IDLE.
            state_d = IDLE;
            if (!bus.flush) begin
               lo_d = q_res;
               hi_d = r_res;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule
